// File: rtl/fifo_wr_arbiter_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// fifo_wr_arbiter_pkg : state encoding and helpers for the FIFO write arbiter
// Rev 1.0
// ----------------------------------------------------------------------------
package fifo_wr_arbiter_pkg;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    localparam int BEAT_CNT_W = 8;

    function automatic int clog2(input int value);
        int r;
        int v;
        r = 0;
        v = value - 1;
        while (v > 0) begin
            r = r + 1;
            v = v >> 1;
        end
        return r;
    endfunction

endpackage : fifo_wr_arbiter_pkg
`default_nettype wire

// File: rtl/fifo_wr_arbiter_rr_priority_picker.sv
`default_nettype none
// ----------------------------------------------------------------------------
// rr_priority_picker : first set request at or above rr_ptr, wrapping upward
// Rev 1.0
// ----------------------------------------------------------------------------
module rr_priority_picker #(
    parameter int NUM_REQ = 4,
    parameter int PTR_W   = 2
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [PTR_W-1:0]   rr_ptr,
    output logic [PTR_W-1:0]   winner,
    output logic               any_req
);

    localparam logic [PTR_W:0] c_num_req = (PTR_W+1)'(NUM_REQ);

    logic [2*NUM_REQ-1:0] w_req_dbl;
    logic [NUM_REQ-1:0]   w_rot;
    logic [PTR_W-1:0]     w_rot_idx;
    logic [PTR_W:0]       w_sum;

    assign w_req_dbl = {req, req};
    assign any_req   = |req;

    // Rotating through a doubled vector keeps the wrap free of modulo logic.
    generate
        for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_rot
            assign w_rot[gi] = w_req_dbl[gi + int'(rr_ptr)];
        end
    endgenerate

    always_comb begin
        w_rot_idx = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (w_rot[i]) begin
                w_rot_idx = PTR_W'(i);
            end
        end
    end

    assign w_sum  = {1'b0, w_rot_idx} + {1'b0, rr_ptr};
    assign winner = (w_sum >= c_num_req) ? PTR_W'(w_sum - c_num_req) : w_sum[PTR_W-1:0];

endmodule : rr_priority_picker
`default_nettype wire

// File: rtl/fifo_wr_arbiter.sv
`default_nettype none
// ----------------------------------------------------------------------------
// fifo_wr_arbiter : round-robin burst arbiter for the async FIFO write port
// Rev 1.0
// ----------------------------------------------------------------------------
module fifo_wr_arbiter
    import fifo_wr_arbiter_pkg::*;
#(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 8,
    parameter int MAX_BURST  = 8
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_REQ-1:0]            req,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] data_in,
    input  logic [NUM_REQ-1:0]            last,
    input  logic                          w_full,
    output logic [NUM_REQ-1:0]            gnt,
    output logic                          w_en,
    output logic [DATA_WIDTH-1:0]         w_data,
    output logic                          busy
);

    localparam int                    PTR_W       = clog2(NUM_REQ);
    localparam logic [BEAT_CNT_W-1:0] c_beat_last = BEAT_CNT_W'(MAX_BURST - 1);
    localparam logic [PTR_W-1:0]      c_idx_last  = PTR_W'(NUM_REQ - 1);

    state_t                  state_q;
    logic [NUM_REQ-1:0]      gnt_q;
    logic [PTR_W-1:0]        rr_ptr_q;
    logic [PTR_W-1:0]        rr_ptr_d;
    logic [PTR_W-1:0]        gidx_q;
    logic [BEAT_CNT_W-1:0]   beat_cnt_q;
    logic [BEAT_CNT_W-1:0]   beat_cnt_d;

    logic [PTR_W-1:0]        w_winner;
    logic                    w_any_req;
    logic                    w_granted;
    logic                    w_req_g;
    logic                    w_last_g;
    logic                    w_accept;
    logic                    w_burst_end;
    logic                    w_release;

    rr_priority_picker #(
        .NUM_REQ (NUM_REQ),
        .PTR_W   (PTR_W)
    ) u_picker (
        .req     (req),
        .rr_ptr  (rr_ptr_q),
        .winner  (w_winner),
        .any_req (w_any_req)
    );

    assign w_granted   = (state_q == GRANT);
    assign w_req_g     = req[gidx_q];
    assign w_last_g    = last[gidx_q];
    assign w_accept    = w_granted & w_req_g & ~w_full;
    assign w_burst_end = w_accept & (w_last_g | (beat_cnt_q == c_beat_last));
    // A dropped request releases even while the FIFO is full.
    assign w_release   = w_granted & (w_burst_end | ~w_req_g);

    assign rr_ptr_d   = (gidx_q == c_idx_last) ? '0 : gidx_q + 1'b1;
    assign beat_cnt_d = w_accept ? beat_cnt_q + 1'b1 : beat_cnt_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            gnt_q      <= '0;
            rr_ptr_q   <= '0;
            gidx_q     <= '0;
            beat_cnt_q <= '0;
        end else if (state_q == IDLE) begin
            if (w_any_req) begin
                state_q    <= GRANT;
                gnt_q      <= NUM_REQ'(1) << w_winner;
                gidx_q     <= w_winner;
                beat_cnt_q <= '0;
            end
        end else begin
            beat_cnt_q <= beat_cnt_d;
            if (w_release) begin
                state_q  <= IDLE;
                gnt_q    <= '0;
                rr_ptr_q <= rr_ptr_d;
            end
        end
    end

    assign gnt    = gnt_q;
    assign busy   = w_granted;
    assign w_en   = w_accept;
    assign w_data = w_granted ? data_in[int'(gidx_q)*DATA_WIDTH +: DATA_WIDTH] : '0;

endmodule : fifo_wr_arbiter
`default_nettype wire

// File: tb/tb_fifo_wr_arbiter.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_fifo_wr_arbiter : directed stimulus with a write scoreboard for the arbiter
// Rev 1.0
// ----------------------------------------------------------------------------
module tb_fifo_wr_arbiter;

    logic        clk;
    logic        rst;
    logic [3:0]  req;
    logic [31:0] data_in;
    logic [3:0]  last;
    logic        w_full;
    logic [3:0]  gnt;
    logic        w_en;
    logic [7:0]  w_data;
    logic        busy;

    int errors = 0;
    int checks = 0;

    typedef struct packed {
        logic [3:0] g;
        logic [7:0] d;
    } exp_t;

    exp_t exp_q[$];

    fifo_wr_arbiter #(
        .NUM_REQ    (4),
        .DATA_WIDTH (8),
        .MAX_BURST  (8)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .req     (req),
        .data_in (data_in),
        .last    (last),
        .w_full  (w_full),
        .gnt     (gnt),
        .w_en    (w_en),
        .w_data  (w_data),
        .busy    (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_data(input int idx, input logic [7:0] val);
        data_in[idx*8 +: 8] = val;
    endtask

    task automatic push(input logic [3:0] g, input logic [7:0] d, input int n);
        exp_t e;
        e.g = g;
        e.d = d;
        for (int i = 0; i < n; i++) exp_q.push_back(e);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        checks++;
        if (act !== exp_v) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp_v);
        end
    endtask

    // Every accepted write must match the next hand-computed entry.
    always @(negedge clk) begin
        if (w_en === 1'b1) begin
            exp_t e;
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_write: got gnt=%b data=%0h expected no write", gnt, w_data);
            end else begin
                e = exp_q.pop_front();
                if (gnt !== e.g || w_data !== e.d) begin
                    errors++;
                    $display("FAIL write: got gnt=%b data=%0h expected gnt=%b data=%0h",
                             gnt, w_data, e.g, e.d);
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; req = '0; last = '0; w_full = 1'b0; data_in = '0;
        set_data(0, 8'h10); set_data(1, 8'h21); set_data(2, 8'h32); set_data(3, 8'h43);
        step();
        req = 4'b0101;
        step(); #2;
        chk("rst_gnt", gnt, 0);
        chk("rst_wen", w_en, 0);
        chk("rst_wdata", w_data, 0);
        chk("rst_busy", busy, 0);
        req = '0;
        step();
        rst = 1'b0;

        // 1: two requesters alternate, one-beat bursts
        step();
        req = 4'b0101; last = 4'hF;
        push(4'b0001, 8'h10, 1); push(4'b0100, 8'h32, 1);
        push(4'b0001, 8'h10, 1); push(4'b0100, 8'h32, 1);
        step(); #2;
        chk("t1_gnt_first", gnt, 4'b0001);
        chk("t1_wen_first", w_en, 1);
        step(); #2;
        chk("t1_bubble_gnt", gnt, 0);
        chk("t1_bubble_wdata", w_data, 0);
        step(); #2;
        chk("t1_gnt_second", gnt, 4'b0100);
        repeat (5) step();
        req = '0;
        step(); step();
        chk("t1_queue_empty", exp_q.size(), 0);

        // 2: single requester, MAX_BURST beats then regrant
        step();
        req = 4'b0100; last = '0; set_data(2, 8'h5A);
        push(4'b0100, 8'h5A, 16);
        for (int k = 1; k <= 17; k++) begin
            step(); #2;
            if (k == 8) chk("t2_gnt_beat8", gnt, 4'b0100);
            if (k == 9) chk("t2_bubble_gnt", gnt, 0);
            if (k == 10) chk("t2_regrant", gnt, 4'b0100);
        end
        step();
        req = '0;
        step(); step();
        chk("t2_queue_empty", exp_q.size(), 0);

        // 3: full stalls the burst for 3 cycles without losing beats
        step();
        req = 4'b0010; set_data(1, 8'h77);
        push(4'b0010, 8'h77, 8);
        for (int k = 1; k <= 12; k++) begin
            step();
            if (k == 4) w_full = 1'b1;
            if (k == 7) w_full = 1'b0;
            if (k == 12) req = '0;
            #2;
            if (k >= 4 && k <= 6) begin
                chk("t3_stall_wen", w_en, 0);
                chk("t3_stall_gnt", gnt, 4'b0010);
            end
            if (k == 11) chk("t3_gnt_last_beat", gnt, 4'b0010);
            if (k == 12) chk("t3_released", gnt, 0);
        end
        step();
        chk("t3_queue_empty", exp_q.size(), 0);

        // 4: last arrives while full; release only once accepted
        step();
        req = 4'b0010; last = '0; set_data(1, 8'h11);
        push(4'b0010, 8'h11, 1); push(4'b0010, 8'h22, 1); push(4'b0010, 8'h33, 1);
        step();
        step();
        set_data(1, 8'h22);
        step();
        set_data(1, 8'h33); last = 4'b0010; w_full = 1'b1;
        #2;
        chk("t4_full_wen", w_en, 0);
        chk("t4_full_gnt", gnt, 4'b0010);
        step();
        w_full = 1'b0;
        #2;
        chk("t4_accept_wen", w_en, 1);
        chk("t4_accept_gnt", gnt, 4'b0010);
        step();
        req = '0; last = '0;
        #2;
        chk("t4_released", gnt, 0);
        step();
        chk("t4_queue_empty", exp_q.size(), 0);

        // 5: request drop releases; pointer wraps to 0
        step();
        req = 4'b1000; last = '0; set_data(3, 8'hC3); set_data(1, 8'h21);
        push(4'b1000, 8'hC3, 2); push(4'b0010, 8'h21, 1);
        step();
        step();
        step();
        req = '0;
        #2;
        chk("t5_drop_wen", w_en, 0);
        chk("t5_drop_gnt", gnt, 4'b1000);
        step();
        req = 4'b1010; last = 4'b0010;
        #2;
        chk("t5_released", gnt, 0);
        chk("t5_busy", busy, 0);
        step(); #2;
        chk("t5_wrap_winner", gnt, 4'b0010);
        step();
        req = '0; last = '0;
        step();
        chk("t5_queue_empty", exp_q.size(), 0);

        // 6: asynchronous reset mid-burst
        step();
        req = 4'b0001; last = '0; set_data(0, 8'h10);
        push(4'b0001, 8'h10, 3);
        step();
        step();
        step();
        #1 rst = 1'b1;
        #1;
        chk("t6_rst_gnt", gnt, 0);
        chk("t6_rst_wen", w_en, 0);
        chk("t6_rst_wdata", w_data, 0);
        chk("t6_rst_busy", busy, 0);
        step();
        rst = 1'b0; req = 4'b0101; last = 4'b0001;
        #2;
        chk("t6_idle_gnt", gnt, 0);
        step(); #2;
        chk("t6_first_gnt", gnt, 4'b0001);
        step();
        req = '0; last = '0;
        step(); step();
        chk("t6_queue_empty", exp_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_fifo_wr_arbiter
`default_nettype wire
